sram_port_ctrl: RTL and testbench
=================================

// Module: sram_port_ctrl
// PURPOSE
//  Memory-side stage downstream of the core's m_a_* port: accepts one 16-bit word access at a time
//  (18-bit word address, byte-lane select, req/ack) and drives an external async 16-bit SRAM with
//  programmable wait states. The core holds a request until ack and may re-raise req the cycle after ack.
// PARAMETERS
//  ADDR_W       18  word-address width (m_adr, sram_addr)
//  RD_WAIT       2  SRAM read-access cycles (>=1); sram_oe_n low for exactly RD_WAIT cycles
//  WR_PULSE      2  sram_we_n low width in cycles (>=1)
// PORTS
//  clk         in   1        system clock (single clock domain)
//  rst         in   1        synchronous reset, active-low (rst==0 resets on clk rising edge)
//  m_adr       in   ADDR_W   word address; captured on acceptance
//  m_req       in   1        request; sampled only in IDLE
//  m_write     in   1        1=write, 0=read; captured on acceptance
//  m_sel       in   2        byte lanes: [0]=bits 7:0 (even byte), [1]=bits 15:8 (odd byte)
//  m_wdata     in   16       write data; captured on acceptance
//  m_ack       out  1        one-cycle completion pulse
//  m_rdata     out  16       read data register; valid in ack cycle, held until next read completes
//  busy        out  1        1 whenever state != IDLE
//  sram_addr   out  ADDR_W   SRAM address (registered)
//  sram_dq_o   out  16       SRAM data out
//  sram_dq_oe  out  1        1=drive sram_dq_o onto DQ pins
//  sram_dq_i   in   16       SRAM data in
//  sram_ce_n, sram_oe_n, sram_we_n, sram_lb_n, sram_ub_n  out 1 each  SRAM strobes, active-low
// BEHAVIOUR
//  - All outputs registered. Reset: m_ack=0, m_rdata=0, busy=0, sram_addr=0, sram_dq_o=0,
//    sram_dq_oe=0, all sram_*_n=1, state=IDLE, wait counter=0. Reset mid-access aborts it:
//    strobes high, dq_oe=0 on the next edge; no ack is ever issued for the aborted access.
//  - States: IDLE, RD, WR_SETUP, WR_PULSE, WR_HOLD, ACK. Cycle 0 = IDLE cycle where m_req==1.
//  - IDLE: on m_req, latch m_adr/m_write/m_sel/m_wdata; sram_addr<=m_adr; lb_n<=~sel[0]; ub_n<=~sel[1].
//    m_sel==2'b00: no strobes, go ACK (ack at cycle 1), m_rdata unchanged (read or write).
//    read -> RD (ce_n=0, oe_n=0); write -> WR_SETUP (ce_n=0, dq_oe=1, dq_o=wdata, we_n=1).
//  - RD: held RD_WAIT cycles (cycles 1..RD_WAIT); on last RD edge m_rdata<=sram_dq_i with unselected
//    lanes forced to 0x00; then ACK. Read ack at cycle RD_WAIT+1.
//  - WR_SETUP: 1 cycle, then WR_PULSE: we_n=0 for WR_PULSE cycles, then WR_HOLD: 1 cycle, we_n=1,
//    dq still driven, addr stable; then ACK. Write ack at cycle WR_PULSE+3.
//  - ACK: m_ack=1 exactly one cycle; ce_n/oe_n/we_n/lb_n/ub_n=1, dq_oe=0; m_req NOT sampled in ACK
//    (still carries old request); next state IDLE unconditionally. Ack never high in consecutive cycles.
//  - Back-to-back: req sampled in the IDLE cycle right after ACK; min spacing between acks = latency+1.
//  - Inputs changing during an access are ignored (latched copies used). m_req dropping mid-access
//    does not cancel it; ack still pulses.
//  - DQ bus never driven while sram_oe_n==0 (no contention; ACK/IDLE separate write->read).
//  - Address passes unmodified, no wrap/increment logic; 0x3FFFF is a legal address.
// TESTING
//  1 Reset: hold rst=0 3 cycles with m_req=1 -> all strobes 1, dq_oe=0, m_ack=0, m_rdata=0, busy=0.
//  2 Read, RD_WAIT=2: adr=0x00010, sel=11, SRAM model returns 0xBEEF -> oe_n low cycles 1-2,
//    m_ack=1 at cycle 3 only, m_rdata=0xBEEF; sel=01 same data -> m_rdata=0x00EF.
//  3 Write byte, WR_PULSE=2: adr=0x3FFFF, sel=10, wdata=0xAB00 -> ub_n=0, lb_n=1, we_n low cycles
//    2-3 only, dq_oe high cycles 1-4, ack at cycle 5; model byte 0x7FFFF becomes 0xAB, 0x7FFFE unchanged.
//  4 Back-to-back: write 0x1234 @0x00100 then core re-raises req (read @0x00100) in cycle after ack ->
//    second access accepted in that cycle, no dq_oe/oe_n overlap, read returns 0x1234, acks not adjacent.
//  5 sel=00 read with m_rdata=0xBEEF -> ack at cycle 1, no ce_n/oe_n/we_n activity, m_rdata stays 0xBEEF.
//  6 Reset mid-write: rst=0 in first WR_PULSE cycle -> next cycle we_n=1, dq_oe=0, no ack; after
//    rst=1 a fresh read completes normally with ack at cycle 3.

Source files
------------

// File: rtl/sram_port_ctrl.sv
// Single-word access controller between the core's m_a_* port and an external async 16-bit SRAM.
// Every output is a register; RD_WAIT sets the read access time, WR_PULSE the we_n low width.
module sram_port_ctrl #(
   parameter int ADDR_W   = 18,
   parameter int RD_WAIT  = 2,
   parameter int WR_PULSE = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] m_adr,
   input  logic              m_req,
   input  logic              m_write,
   input  logic [1:0]        m_sel,
   input  logic [15:0]       m_wdata,
   output logic              m_ack,
   output logic [15:0]       m_rdata,
   output logic              busy,
   output logic [ADDR_W-1:0] sram_addr,
   output logic [15:0]       sram_dq_o,
   output logic              sram_dq_oe,
   input  logic [15:0]       sram_dq_i,
   output logic              sram_ce_n,
   output logic              sram_oe_n,
   output logic              sram_we_n,
   output logic              sram_lb_n,
   output logic              sram_ub_n
);

   localparam int MAX_WAIT = (RD_WAIT > WR_PULSE) ? RD_WAIT : WR_PULSE;
   localparam int CNT_W    = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_RD       = 3'd1,
      S_WR_SETUP = 3'd2,
      S_WR_PULSE = 3'd3,
      S_WR_HOLD  = 3'd4,
      S_ACK      = 3'd5
   } state_t;

   state_t              state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [1:0]          sel_q, sel_d;
   logic                ack_q, ack_d;
   logic                busy_q, busy_d;
   logic [15:0]         rdata_q, rdata_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [15:0]         dq_o_q, dq_o_d;
   logic                dq_oe_q, dq_oe_d;
   logic                ce_n_q, ce_n_d;
   logic                oe_n_q, oe_n_d;
   logic                we_n_q, we_n_d;
   logic                lb_n_q, lb_n_d;
   logic                ub_n_q, ub_n_d;

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         sel_q   <= 2'b00;
         ack_q   <= 1'b0;
         busy_q  <= 1'b0;
         rdata_q <= 16'h0000;
         addr_q  <= '0;
         dq_o_q  <= 16'h0000;
         dq_oe_q <= 1'b0;
         ce_n_q  <= 1'b1;
         oe_n_q  <= 1'b1;
         we_n_q  <= 1'b1;
         lb_n_q  <= 1'b1;
         ub_n_q  <= 1'b1;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         sel_q   <= sel_d;
         ack_q   <= ack_d;
         busy_q  <= busy_d;
         rdata_q <= rdata_d;
         addr_q  <= addr_d;
         dq_o_q  <= dq_o_d;
         dq_oe_q <= dq_oe_d;
         ce_n_q  <= ce_n_d;
         oe_n_q  <= oe_n_d;
         we_n_q  <= we_n_d;
         lb_n_q  <= lb_n_d;
         ub_n_q  <= ub_n_d;
      end
   end

   // Every _d describes what the pins must look like during the next cycle.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      sel_d   = sel_q;
      ack_d   = 1'b0;
      rdata_d = rdata_q;
      addr_d  = addr_q;
      dq_o_d  = dq_o_q;
      dq_oe_d = dq_oe_q;
      ce_n_d  = ce_n_q;
      oe_n_d  = oe_n_q;
      we_n_d  = we_n_q;
      lb_n_d  = lb_n_q;
      ub_n_d  = ub_n_q;

      unique case (state_q)
         S_IDLE: begin
            if (m_req) begin
               sel_d  = m_sel;
               addr_d = m_adr;
               lb_n_d = ~m_sel[0];
               ub_n_d = ~m_sel[1];
               if (m_write) begin
                  dq_o_d = m_wdata;
               end
               if (m_sel == 2'b00) begin
                  // No lanes selected: complete without touching the SRAM.
                  state_d = S_ACK;
                  ack_d   = 1'b1;
               end else if (m_write) begin
                  state_d = S_WR_SETUP;
                  ce_n_d  = 1'b0;
                  dq_oe_d = 1'b1;
                  we_n_d  = 1'b1;
               end else begin
                  state_d = S_RD;
                  ce_n_d  = 1'b0;
                  oe_n_d  = 1'b0;
                  cnt_d   = CNT_W'(RD_WAIT - 1);
               end
            end
         end

         S_RD: begin
            if (cnt_q == '0) begin
               rdata_d = {sel_q[1] ? sram_dq_i[15:8] : 8'h00,
                          sel_q[0] ? sram_dq_i[7:0]  : 8'h00};
               state_d = S_ACK;
               ack_d   = 1'b1;
               ce_n_d  = 1'b1;
               oe_n_d  = 1'b1;
               lb_n_d  = 1'b1;
               ub_n_d  = 1'b1;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end

         S_WR_SETUP: begin
            state_d = S_WR_PULSE;
            we_n_d  = 1'b0;
            cnt_d   = CNT_W'(WR_PULSE - 1);
         end

         S_WR_PULSE: begin
            if (cnt_q == '0) begin
               state_d = S_WR_HOLD;
               we_n_d  = 1'b1;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end

         // Data and address stay valid one cycle past the we_n rising edge.
         S_WR_HOLD: begin
            state_d = S_ACK;
            ack_d   = 1'b1;
            ce_n_d  = 1'b1;
            we_n_d  = 1'b1;
            lb_n_d  = 1'b1;
            ub_n_d  = 1'b1;
            dq_oe_d = 1'b0;
         end

         S_ACK: begin
            state_d = S_IDLE;
         end

         default: begin
            state_d = S_IDLE;
            ce_n_d  = 1'b1;
            oe_n_d  = 1'b1;
            we_n_d  = 1'b1;
            lb_n_d  = 1'b1;
            ub_n_d  = 1'b1;
            dq_oe_d = 1'b0;
         end
      endcase

      busy_d = (state_d != S_IDLE);
   end

   assign m_ack      = ack_q;
   assign m_rdata    = rdata_q;
   assign busy       = busy_q;
   assign sram_addr  = addr_q;
   assign sram_dq_o  = dq_o_q;
   assign sram_dq_oe = dq_oe_q;
   assign sram_ce_n  = ce_n_q;
   assign sram_oe_n  = oe_n_q;
   assign sram_we_n  = we_n_q;
   assign sram_lb_n  = lb_n_q;
   assign sram_ub_n  = ub_n_q;

endmodule

// File: tb/tb_sram_port_ctrl.sv
// Bench for sram_port_ctrl: byte-wide async SRAM model, per-cycle strobe traces and an
// expected-read-data queue compared on every ack.
module tb_sram_port_ctrl;

   localparam int ADDR_W   = 18;
   localparam int RD_WAIT  = 2;
   localparam int WR_PULSE = 2;

   logic              clk = 1'b0;
   logic              rst;
   logic [ADDR_W-1:0] m_adr;
   logic              m_req;
   logic              m_write;
   logic [1:0]        m_sel;
   logic [15:0]       m_wdata;
   logic              m_ack;
   logic [15:0]       m_rdata;
   logic              busy;
   logic [ADDR_W-1:0] sram_addr;
   logic [15:0]       sram_dq_o;
   logic              sram_dq_oe;
   logic [15:0]       sram_dq_i;
   logic              sram_ce_n, sram_oe_n, sram_we_n, sram_lb_n, sram_ub_n;

   int n_checks = 0;
   int n_pass   = 0;
   int overlap_cnt = 0;
   int ack_cnt  = 0;
   logic [15:0] exp_q[$];

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   sram_port_ctrl #(.ADDR_W(ADDR_W), .RD_WAIT(RD_WAIT), .WR_PULSE(WR_PULSE)) dut (
      .clk(clk), .rst(rst), .m_adr(m_adr), .m_req(m_req), .m_write(m_write), .m_sel(m_sel),
      .m_wdata(m_wdata), .m_ack(m_ack), .m_rdata(m_rdata), .busy(busy), .sram_addr(sram_addr),
      .sram_dq_o(sram_dq_o), .sram_dq_oe(sram_dq_oe), .sram_dq_i(sram_dq_i),
      .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n), .sram_we_n(sram_we_n),
      .sram_lb_n(sram_lb_n), .sram_ub_n(sram_ub_n)
   );

   // ---------------- SRAM model (byte addressed) ----------------
   logic [7:0]  mem [0:(1<<19)-1];
   logic        pre_en = 1'b0;
   logic [18:0] pre_addr = '0;
   logic [7:0]  pre_data = '0;

   assign sram_dq_i = (!sram_ce_n && !sram_oe_n) ?
                      {mem[{sram_addr, 1'b1}], mem[{sram_addr, 1'b0}]} : 16'hDEAD;

   always @(posedge clk) begin
      if (pre_en) begin
         mem[pre_addr] <= pre_data;
      end else if (!sram_ce_n && !sram_we_n && sram_dq_oe) begin
         if (!sram_lb_n) mem[{sram_addr, 1'b0}] <= sram_dq_o[7:0];
         if (!sram_ub_n) mem[{sram_addr, 1'b1}] <= sram_dq_o[15:8];
      end
   end

   always @(negedge clk) begin
      if (sram_dq_oe && !sram_oe_n) overlap_cnt++;
      if (m_ack) ack_cnt++;
   end

   // ---------------- checking ----------------
   task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      else n_pass++;
   endtask

   // ---------------- driver tasks ----------------
   task automatic preload(input logic [18:0] a, input logic [7:0] d);
      pre_addr = a;
      pre_data = d;
      pre_en   = 1'b1;
      @(posedge clk); #1;
      pre_en   = 1'b0;
   endtask

   // Call at posedge+1; returns at posedge+1 of the cycle after ack with m_req still high
   // when keep_req is set, so the next call lands in the IDLE cycle right after ACK.
   task automatic do_access(input bit wr, input logic [ADDR_W-1:0] adr, input logic [1:0] sel,
                            input logic [15:0] wd, input logic [15:0] exp_rd, input bit keep_req);
      logic [63:0] oe_m, we_m, ce_m, dqoe_m, lb_m, ub_m, ack_m, busy_m;
      logic [63:0] act_rd, act_wr_ce, act_we, act_busy, exp_ce, exp_oe, exp_we, exp_dqoe;
      logic [ADDR_W-1:0] addr_c1;
      int lat_exp, c;
      bit got;
      lat_exp = (sel == 2'b00) ? 1 : (wr ? WR_PULSE + 3 : RD_WAIT + 1);
      if (!wr) exp_q.push_back(exp_rd);
      m_req = 1'b1; m_write = wr; m_adr = adr; m_sel = sel; m_wdata = wd;
      {oe_m, we_m, ce_m, dqoe_m, lb_m, ub_m, ack_m, busy_m} = '0;
      addr_c1 = '0;
      got = 1'b0;
      c = 0;
      while (!got && c < 40) begin
         @(negedge clk);
         oe_m[c] = ~sram_oe_n;  we_m[c] = ~sram_we_n;  ce_m[c] = ~sram_ce_n;
         dqoe_m[c] = sram_dq_oe; lb_m[c] = ~sram_lb_n; ub_m[c] = ~sram_ub_n;
         ack_m[c] = m_ack;      busy_m[c] = busy;
         if (c == 1) addr_c1 = sram_addr;
         if (m_ack) begin
            got = 1'b1;
            if (!wr) check_eq("rdata", m_rdata, exp_q.pop_front());
         end
         @(posedge clk); #1;
         // Scramble inputs once accepted: the access must run from latched copies.
         if (c == 0) begin
            m_adr = ADDR_W'($urandom); m_wdata = 16'($urandom);
            m_sel = 2'($urandom);      m_write = 1'($urandom);
         end
         c++;
      end
      if (!keep_req) m_req = 1'b0;
      act_rd    = ((64'd1 << (RD_WAIT + 1)) - 1) & ~64'd1;
      act_wr_ce = ((64'd1 << (WR_PULSE + 3)) - 1) & ~64'd1;
      act_we    = ((64'd1 << (WR_PULSE + 2)) - 1) & ~64'd3;
      act_busy  = ((64'd1 << (lat_exp + 1)) - 1) & ~64'd1;
      exp_ce    = (sel == 2'b00) ? 64'd0 : (wr ? act_wr_ce : act_rd);
      exp_oe    = (sel != 2'b00 && !wr) ? act_rd : 64'd0;
      exp_we    = (sel != 2'b00 && wr) ? act_we : 64'd0;
      exp_dqoe  = (sel != 2'b00 && wr) ? act_wr_ce : 64'd0;
      check_eq("ack_seen", 64'(got), 64'd1);
      check_eq("ack_trace", ack_m, 64'd1 << lat_exp);
      check_eq("busy_trace", busy_m, act_busy);
      check_eq("ce_trace", ce_m, exp_ce);
      check_eq("oe_trace", oe_m, exp_oe);
      check_eq("we_trace", we_m, exp_we);
      check_eq("dqoe_trace", dqoe_m, exp_dqoe);
      check_eq("lb_trace", lb_m, sel[0] ? exp_ce : 64'd0);
      check_eq("ub_trace", ub_m, sel[1] ? exp_ce : 64'd0);
      check_eq("sram_addr", 64'(addr_c1), 64'(adr));
   endtask

   // ---------------- stimulus ----------------
   initial begin
      logic [ADDR_W-1:0] adr_tbl [6];
      logic [15:0]       dat_tbl [6];
      logic [1:0]        rsel;
      int                ack_before;

      rst = 1'b0; m_req = 1'b1; m_write = 1'b0; m_adr = 18'h00123; m_sel = 2'b11; m_wdata = 16'h0;
      repeat (3) @(posedge clk);
      #1;
      // Test 1: reset with req held
      @(negedge clk);
      check_eq("rst_strobes", {sram_ce_n, sram_oe_n, sram_we_n, sram_lb_n, sram_ub_n}, 5'b11111);
      check_eq("rst_dq_oe", sram_dq_oe, 1'b0);
      check_eq("rst_ack", m_ack, 1'b0);
      check_eq("rst_rdata", m_rdata, 16'h0000);
      check_eq("rst_busy", busy, 1'b0);
      check_eq("rst_addr", sram_addr, 18'h0);
      m_req = 1'b0;
      @(posedge clk); #1;
      preload(19'h00020, 8'hEF);
      preload(19'h00021, 8'hBE);
      preload(19'h7FFFE, 8'h55);
      preload(19'h7FFFF, 8'h66);
      rst = 1'b1;
      @(posedge clk); #1;

      // Test 2: reads
      do_access(1'b0, 18'h00010, 2'b11, 16'h0, 16'hBEEF, 1'b0);
      @(posedge clk); #1;
      do_access(1'b0, 18'h00010, 2'b01, 16'h0, 16'h00EF, 1'b0);
      do_access(1'b0, 18'h00010, 2'b10, 16'h0, 16'hBE00, 1'b0);

      // Test 3: odd-byte write at the top address
      do_access(1'b1, 18'h3FFFF, 2'b10, 16'hAB00, 16'h0, 1'b0);
      check_eq("mem_hi", mem[19'h7FFFF], 8'hAB);
      check_eq("mem_lo", mem[19'h7FFFE], 8'h55);

      // Test 4: back-to-back write then read of the same word
      do_access(1'b1, 18'h00100, 2'b11, 16'h1234, 16'h0, 1'b1);
      do_access(1'b0, 18'h00100, 2'b11, 16'h0, 16'h1234, 1'b0);

      // Test 5: sel=00 leaves m_rdata alone
      do_access(1'b0, 18'h00010, 2'b11, 16'h0, 16'hBEEF, 1'b0);
      do_access(1'b0, 18'h00010, 2'b00, 16'h0, 16'hBEEF, 1'b1);
      do_access(1'b1, 18'h00010, 2'b00, 16'h5A5A, 16'h0, 1'b0);
      check_eq("sel00_wr_mem", {mem[19'h00021], mem[19'h00020]}, 16'hBEEF);

      // Test 6: reset during the first we_n-low cycle
      ack_before = ack_cnt;
      m_req = 1'b1; m_write = 1'b1; m_adr = 18'h00200; m_sel = 2'b11; m_wdata = 16'hCAFE;
      @(posedge clk); #1;
      @(posedge clk); #1;
      @(negedge clk);
      check_eq("abort_we_low", sram_we_n, 1'b0);
      rst = 1'b0;
      @(posedge clk); #1;
      m_req = 1'b0;
      @(negedge clk);
      check_eq("abort_we_n", sram_we_n, 1'b1);
      check_eq("abort_dq_oe", sram_dq_oe, 1'b0);
      check_eq("abort_ce_n", sram_ce_n, 1'b1);
      check_eq("abort_busy", busy, 1'b0);
      @(posedge clk); #1;
      rst = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      check_eq("abort_no_ack", ack_cnt, ack_before);
      do_access(1'b0, 18'h00010, 2'b11, 16'h0, 16'hBEEF, 1'b0);

      // Random write/read-back pairs on distinct addresses
      for (int i = 0; i < 6; i++) begin
         adr_tbl[i] = {3'(i), 15'($urandom)};
         dat_tbl[i] = 16'($urandom);
         do_access(1'b1, adr_tbl[i], 2'b11, dat_tbl[i], 16'h0, 1'($urandom_range(0, 1)));
         check_eq("rand_wr_mem", {mem[{adr_tbl[i], 1'b1}], mem[{adr_tbl[i], 1'b0}]}, dat_tbl[i]);
      end
      for (int i = 0; i < 6; i++) begin
         rsel = 2'($urandom_range(1, 3));
         do_access(1'b0, adr_tbl[i], rsel,  16'h0,
                   {rsel[1] ? dat_tbl[i][15:8] : 8'h00, rsel[0] ? dat_tbl[i][7:0] : 8'h00},
                   1'($urandom_range(0, 1)));
      end
      m_req = 1'b0;
      repeat (3) @(posedge clk);

      check_eq("no_dq_overlap", overlap_cnt, 0);
      check_eq("exp_q_empty", exp_q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
